sid_write_sched: RTL and testbench
==================================

SID_WRITE_SCHED -- requirements
Module: sid_write_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning FIFO entries; power of two, range 2..64.
REQ-002 SHALL have parameter DELAY_W, default 16, meaning width of per-entry delay field in clkEn ticks.
REQ-003 SHALL have port clk  input  1  master clock; one clock domain, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port clkEn  input  1  1 MHz tick enable, same as the SID core's tick.
REQ-006 SHALL have port iValid  input  1  host entry valid.
REQ-007 SHALL have port oReady  output  1  FIFO accepts entry this cycle.
REQ-008 SHALL have port iDelay  input  DELAY_W  clkEn ticks to wait before the entry's write issues.
REQ-009 SHALL have port iAddr  input  5  SID register address.
REQ-010 SHALL have port iData  input  8  SID register data.
REQ-011 SHALL have port iFlush  input  1  discard queued and waiting entries.
REQ-012 SHALL have port iHold  input  1  freeze delay countdown (player pause).
REQ-013 SHALL have port oSidWE  output  1  write strobe to SID core iWE.
REQ-014 SHALL have port oSidAddr  output  5  to SID core iAddr.
REQ-015 SHALL have port oSidData  output  8  to SID core iDataW.
REQ-016 SHALL have port oLevel  output  clog2(DEPTH)+1  FIFO occupancy.
REQ-017 SHALL have port oBusy  output  1  high if FIFO non-empty or state not IDLE.

Function
REQ-018 Push SHALL occur at a rising edge where iValid && oReady; oReady = !full && !iFlush && !rst.
REQ-019 oReady SHALL be low when full even if a pop occurs the same cycle; no push-while-full bypass.
REQ-020 FIFO SHALL be first-in first-out, read and write pointers wrapping modulo DEPTH; oLevel exact at every edge, including simultaneous push and pop (level unchanged).
REQ-021 The FSM SHALL have three states: IDLE, WAIT, ISSUE.
REQ-022 IDLE with FIFO non-empty: pop head into holding regs {count=delay, addr, data}; next state WAIT if delay != 0, else ISSUE.
REQ-023 IDLE with FIFO empty: remain IDLE.
REQ-024 WAIT: at each edge with clkEn=1 and iHold=0, decrement count; if count==1 at that edge, next state is ISSUE.
REQ-025 WAIT with clkEn=0 or iHold=1: count and state SHALL hold.
REQ-026 ISSUE: oSidWE=1 for exactly one clk cycle, with oSidAddr/oSidData equal to the held entry; next state IDLE unconditionally.
REQ-027 oSidWE, oSidAddr and oSidData SHALL be registered outputs; oSidAddr/oSidData hold their last value when oSidWE=0.
REQ-028 Delay semantics: an entry with delay D>0 SHALL issue after exactly D qualifying clkEn edges counted from the edge after its pop; D=0 issues immediately after pop.
REQ-029 Latency: a delay-0 entry pushed at edge t into an idle empty block SHALL give oSidWE=1 sampled at edge t+2 only; minimum spacing of back-to-back delay-0 writes is 2 clk cycles.
REQ-030 Max delay SHALL be 2^DELAY_W-1; no wrap of count below 0.
REQ-031 iFlush sampled high SHALL empty the FIFO (oLevel=0), force state to IDLE and abort any WAIT entry; a strobe already high in the flush cycle completes; no strobe in the following cycle.
REQ-032 iFlush SHALL have priority over push, pop and countdown in the same cycle.
REQ-033 iHold SHALL NOT block pushes, pops in IDLE, or an ISSUE already entered.

Reset
REQ-034 While rst=1: FIFO empty, pointers 0, state IDLE, count 0, oSidWE=0, oSidAddr=0, oSidData=0, oLevel=0, oBusy=0, oReady=0.
REQ-035 rst asserted mid-WAIT or mid-ISSUE SHALL drop oSidWE immediately (asynchronously) and discard all entries.
REQ-036 After rst deassertion the block SHALL accept pushes on the first edge (oReady=1).

Verification
REQ-037 Push {D=0,A=0x18,Dt=0x0F} at edge t into idle block -> oSidWE=1 at edge t+2 only, oSidAddr=0x18, oSidData=0x0F.
REQ-038 Push {D=3,A=0x04,Dt=0x41}, clkEn every 20 clk -> exactly one strobe, on the cycle after the 3rd clkEn edge following pop; iHold high across one clkEn -> strobe delayed by exactly one clkEn period.
REQ-039 Push DEPTH+2 entries back-to-back with D=5 -> oReady low when oLevel=DEPTH, writes issue in push order, spacing 5 clkEn ticks, oLevel returns to 0, oBusy then low.
REQ-040 Queue 4 entries, assert iFlush for one cycle while in WAIT -> no further strobes, oLevel=0, state IDLE, iValid in the flush cycle is ignored.
REQ-041 Assert rst asynchronously while in ISSUE -> oSidWE falls before next clk edge; after release, oLevel=0 and oReady=1.

Source files
------------

// File: rtl/sid_write_sched.sv
// sid_write_sched
// ----------------
// Timed write scheduler placed in front of a SID core. The host queues
// {delay, addr, data} entries in a small FIFO; each entry is popped in order,
// waits for its delay measured in clkEn ticks, then drives a single-cycle
// write strobe towards the SID core.
//
// Ports
//   clk       master clock, all logic on the rising edge
//   rst       asynchronous active-high reset
//   clkEn     1 MHz tick enable (same tick the SID core uses)
//   iValid    host entry valid; accepted on an edge where oReady is high
//   oReady    FIFO can accept an entry this cycle
//   iDelay    clkEn ticks to wait before the entry's write issues
//   iAddr     SID register address of the entry
//   iData     SID register data of the entry
//   iFlush    discard queued entries and abort any waiting entry
//   iHold     freeze the delay countdown (player pause)
//   oSidWE    registered write strobe to the SID core
//   oSidAddr  registered write address to the SID core
//   oSidData  registered write data to the SID core
//   oLevel    FIFO occupancy
//   oBusy     FIFO non-empty or scheduler not idle
module sid_write_sched #(
    parameter int DEPTH   = 8,
    parameter int DELAY_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clkEn,
    input  logic                     iValid,
    output logic                     oReady,
    input  logic [DELAY_W-1:0]       iDelay,
    input  logic [4:0]               iAddr,
    input  logic [7:0]               iData,
    input  logic                     iFlush,
    input  logic                     iHold,
    output logic                     oSidWE,
    output logic [4:0]               oSidAddr,
    output logic [7:0]               oSidData,
    output logic [$clog2(DEPTH):0]   oLevel,
    output logic                     oBusy
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    // Stored entry layout: {delay, addr[4:0], data[7:0]}
    localparam int EW = DELAY_W + 13;

    localparam logic [DELAY_W-1:0] CNT_ZERO = {DELAY_W{1'b0}};
    localparam logic [DELAY_W-1:0] CNT_ONE  = DELAY_W'(1'b1);
    localparam logic [LW-1:0]      LVL_ZERO = {LW{1'b0}};
    localparam logic [LW-1:0]      LVL_ONE  = LW'(1'b1);
    localparam logic [LW-1:0]      LVL_FULL = LW'(DEPTH);
    localparam logic [AW-1:0]      PTR_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0]      PTR_ONE  = AW'(1'b1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ISSUE = 2'd2
    } state_t;

    logic [EW-1:0]      fifoMem [DEPTH];
    logic [AW-1:0]      wrPtr;
    logic [AW-1:0]      rdPtr;
    logic [LW-1:0]      levelR;

    state_t             stateR;
    state_t             stateN;
    logic [DELAY_W-1:0] countR;
    logic [4:0]         holdAddr;
    logic [7:0]         holdData;

    logic               fifoFull;
    logic               fifoEmpty;
    logic               pushS;
    logic               popS;
    logic               decS;

    logic [EW-1:0]      headEntry;
    logic [DELAY_W-1:0] headDelay;
    logic [4:0]         headAddr;
    logic [7:0]         headData;

    assign fifoFull  = (levelR == LVL_FULL);
    assign fifoEmpty = (levelR == LVL_ZERO);

    // No push-while-full bypass: a pop in the same cycle does not free a slot
    // early, and a flush or reset refuses new entries outright.
    assign oReady = !fifoFull && !iFlush && !rst;
    assign pushS  = iValid && oReady;

    assign headEntry = fifoMem[rdPtr];
    assign headDelay = headEntry[EW-1:13];
    assign headAddr  = headEntry[12:8];
    assign headData  = headEntry[7:0];

    assign oLevel = levelR;
    assign oBusy  = (levelR != LVL_ZERO) || (stateR != IDLE);

    // FIFO storage; contents need no reset because pointers and level define validity
    always_ff @(posedge clk) begin
        if (pushS) begin
            fifoMem[wrPtr] <= {iDelay, iAddr, iData};
        end
    end

    // Scheduler state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateR <= IDLE;
        end else begin
            stateR <= stateN;
        end
    end

    // Next-state decode plus pop / countdown controls; flush overrides everything
    always_comb begin
        stateN = stateR;
        popS   = 1'b0;
        decS   = 1'b0;
        if (iFlush) begin
            stateN = IDLE;
        end else begin
            case (stateR)
                IDLE: begin
                    if (!fifoEmpty) begin
                        popS = 1'b1;
                        if (headDelay != CNT_ZERO) begin
                            stateN = WAIT;
                        end else begin
                            stateN = ISSUE;
                        end
                    end else begin
                        stateN = IDLE;
                    end
                end
                WAIT: begin
                    if (clkEn && !iHold) begin
                        decS = 1'b1;
                        // A count of zero cannot occur here; treating it as the
                        // final tick keeps the counter from ever wrapping.
                        if (countR <= CNT_ONE) begin
                            stateN = ISSUE;
                        end else begin
                            stateN = WAIT;
                        end
                    end else begin
                        stateN = WAIT;
                    end
                end
                ISSUE: begin
                    stateN = IDLE;
                end
                default: begin
                    stateN = IDLE;
                end
            endcase
        end
    end

    // FIFO pointers, occupancy and the holding registers of the active entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr    <= PTR_ZERO;
            rdPtr    <= PTR_ZERO;
            levelR   <= LVL_ZERO;
            countR   <= CNT_ZERO;
            holdAddr <= 5'd0;
            holdData <= 8'd0;
        end else if (iFlush) begin
            wrPtr  <= PTR_ZERO;
            rdPtr  <= PTR_ZERO;
            levelR <= LVL_ZERO;
            countR <= CNT_ZERO;
        end else begin
            if (pushS) begin
                wrPtr <= wrPtr + PTR_ONE;
            end
            if (popS) begin
                rdPtr <= rdPtr + PTR_ONE;
            end
            case ({pushS, popS})
                2'b10:   levelR <= levelR + LVL_ONE;
                2'b01:   levelR <= levelR - LVL_ONE;
                default: levelR <= levelR;
            endcase
            if (popS) begin
                countR   <= headDelay;
                holdAddr <= headAddr;
                holdData <= headData;
            end else if (decS && (countR != CNT_ZERO)) begin
                countR <= countR - CNT_ONE;
            end
        end
    end

    // Registered SID write port: the strobe is high exactly while in ISSUE.
    // A zero-delay entry goes straight from the FIFO head to the port because
    // the holding registers load on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oSidWE   <= 1'b0;
            oSidAddr <= 5'd0;
            oSidData <= 8'd0;
        end else begin
            oSidWE <= (stateN == ISSUE);
            if (stateN == ISSUE) begin
                oSidAddr <= popS ? headAddr : holdAddr;
                oSidData <= popS ? headData : holdData;
            end
        end
    end

endmodule

// File: tb/tb_sid_write_sched.sv
`timescale 1ns/1ps
module tb_sid_write_sched;

    localparam int DEPTH   = 8;
    localparam int DELAY_W = 16;
    localparam int LW      = $clog2(DEPTH) + 1;

    logic               clk;
    logic               rst;
    logic               clkEn;
    logic               iValid;
    logic               oReady;
    logic [DELAY_W-1:0] iDelay;
    logic [4:0]         iAddr;
    logic [7:0]         iData;
    logic               iFlush;
    logic               iHold;
    logic               oSidWE;
    logic [4:0]         oSidAddr;
    logic [7:0]         oSidData;
    logic [LW-1:0]      oLevel;
    logic               oBusy;

    typedef struct {
        logic [4:0] a;
        logic [7:0] d;
        int         c;
    } exp_t;

    exp_t       expQ[$];
    logic [4:0] obsA[$];
    logic [7:0] obsD[$];
    int         obsC[$];
    int         obsRd      = 0;
    int         cyc        = 0;
    int         cePeriod   = 0;
    int         compared   = 0;
    int         mismatched = 0;

    sid_write_sched #(.DEPTH(DEPTH), .DELAY_W(DELAY_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .clkEn   (clkEn),
        .iValid  (iValid),
        .oReady  (oReady),
        .iDelay  (iDelay),
        .iAddr   (iAddr),
        .iData   (iData),
        .iFlush  (iFlush),
        .iHold   (iHold),
        .oSidWE  (oSidWE),
        .oSidAddr(oSidAddr),
        .oSidData(oSidData),
        .oLevel  (oLevel),
        .oBusy   (oBusy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge counter: after rising edge n, cyc reads n
    always @(posedge clk) cyc <= cyc + 1;

    // clkEn is high at edge e exactly when (e-1) % cePeriod == 0
    initial begin
        clkEn = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (cePeriod == 0) clkEn = 1'b0;
            else clkEn = ((cyc % cePeriod) == 0);
        end
    end

    // Strobe monitor: records each high strobe cycle, tagged with the edge that raised it
    always @(negedge clk) begin
        if (oSidWE === 1'b1) begin
            obsA.push_back(oSidAddr);
            obsD.push_back(oSidData);
            obsC.push_back(cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog sim time exceeded, compared=%0d mismatched=%0d", compared, mismatched);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int nextCe(input int e, input int p);
        int n;
        n = e + 1;
        while (((n - 1) % p) != 0) n++;
        return n;
    endfunction

    // Expected strobe edge: pop one edge after push or two edges after the previous
    // strobe, then count d qualifying clkEn edges after the pop edge.
    function automatic int modelObs(input int pushEdge, input int prevObs, input int d, input int p);
        int e;
        e = (pushEdge + 1 > prevObs + 2) ? pushEdge + 1 : prevObs + 2;
        for (int k = 0; k < d; k++) e = nextCe(e, p);
        return e;
    endfunction

    task automatic pushEntry(input logic [DELAY_W-1:0] d, input logic [4:0] a, input logic [7:0] dt,
                             output int tEdge, output bit ok);
        int k;
        k = 0;
        iValid = 1'b1;
        iDelay = d;
        iAddr  = a;
        iData  = dt;
        while (oReady !== 1'b1 && k < 500) begin
            tick();
            k++;
        end
        ok = (oReady === 1'b1);
        @(posedge clk);
        #1;
        tEdge  = cyc;
        iValid = 1'b0;
    endtask

    task automatic waitObs(input int n, input int budget);
        int k;
        k = 0;
        while ((obsA.size() - obsRd) < n && k < budget) begin
            tick();
            k++;
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        compared++; if (oSidWE !== 1'b0) begin mismatched++; $display("FAIL reset_we got %b want 0", oSidWE); end
        compared++; if (oSidAddr !== 5'h00) begin mismatched++; $display("FAIL reset_addr got %h want 00", oSidAddr); end
        compared++; if (oSidData !== 8'h00) begin mismatched++; $display("FAIL reset_data got %h want 00", oSidData); end
        compared++; if (oLevel !== 4'd0) begin mismatched++; $display("FAIL reset_level got %0d want 0", oLevel); end
        compared++; if (oBusy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got %b want 0", oBusy); end
        compared++; if (oReady !== 1'b0) begin mismatched++; $display("FAIL reset_ready got %b want 0", oReady); end
        rst = 1'b0;
        #1;
        compared++; if (oReady !== 1'b1) begin mismatched++; $display("FAIL reset_release_ready got %b want 1", oReady); end
    endtask

    task automatic test_zero_delay();
        int t;
        bit ok;
        exp_t e;
        cePeriod = 0;
        pushEntry(16'd0, 5'h18, 8'h0F, t, ok);
        expQ.push_back('{a: 5'h18, d: 8'h0F, c: modelObs(t, -100, 0, 1)});
        compared++; if (!ok || oLevel !== 4'd1) begin mismatched++; $display("FAIL zero_push_level got %0d want 1", oLevel); end
        tick();
        compared++; if (oSidWE !== 1'b1) begin mismatched++; $display("FAIL zero_we_t2 got %b want 1", oSidWE); end
        tick();
        compared++; if (oSidWE !== 1'b0) begin mismatched++; $display("FAIL zero_we_t3 got %b want 0", oSidWE); end
        repeat (4) tick();
        while (expQ.size() > 0 && obsRd < obsA.size()) begin
            e = expQ.pop_front();
            compared++;
            if (obsA[obsRd] !== e.a || obsD[obsRd] !== e.d || obsC[obsRd] != e.c) begin
                mismatched++;
                $display("FAIL zero_write got a=%h d=%h edge=%0d want a=%h d=%h edge=%0d",
                         obsA[obsRd], obsD[obsRd], obsC[obsRd], e.a, e.d, e.c);
            end
            obsRd++;
        end
        compared++;
        if (expQ.size() != 0 || obsRd != obsA.size()) begin
            mismatched++;
            $display("FAIL zero_count got missing=%0d extra=%0d want 0/0", expQ.size(), obsA.size() - obsRd);
            expQ.delete();
            obsRd = obsA.size();
        end
        compared++; if (oBusy !== 1'b0) begin mismatched++; $display("FAIL zero_busy_after got %b want 0", oBusy); end
    endtask

    task automatic test_back_to_back();
        int t;
        int prev;
        bit ok;
        exp_t e;
        cePeriod = 0;
        prev = -100;
        for (int i = 0; i < 3; i++) begin
            pushEntry(16'd0, 5'(5'h10 + i), 8'(8'hA0 + i), t, ok);
            prev = modelObs(t, prev, 0, 1);
            expQ.push_back('{a: 5'(5'h10 + i), d: 8'(8'hA0 + i), c: prev});
        end
        waitObs(3, 40);
        repeat (4) tick();
        while (expQ.size() > 0 && obsRd < obsA.size()) begin
            e = expQ.pop_front();
            compared++;
            if (obsA[obsRd] !== e.a || obsD[obsRd] !== e.d || obsC[obsRd] != e.c) begin
                mismatched++;
                $display("FAIL b2b_write got a=%h d=%h edge=%0d want a=%h d=%h edge=%0d",
                         obsA[obsRd], obsD[obsRd], obsC[obsRd], e.a, e.d, e.c);
            end
            obsRd++;
        end
        compared++;
        if (expQ.size() != 0 || obsRd != obsA.size()) begin
            mismatched++;
            $display("FAIL b2b_count got missing=%0d extra=%0d want 0/0", expQ.size(), obsA.size() - obsRd);
            expQ.delete();
            obsRd = obsA.size();
        end
    endtask

    task automatic test_delay_hold();
        int t;
        int e1;
        int e2;
        bit ok;
        exp_t e;
        cePeriod = 20;
        repeat (3) tick();
        // Plain delay of 3 ticks
        pushEntry(16'd3, 5'h04, 8'h41, t, ok);
        expQ.push_back('{a: 5'h04, d: 8'h41, c: modelObs(t, -100, 3, 20)});
        tick();
        compared++; if (oBusy !== 1'b1 || oLevel !== 4'd0) begin mismatched++; $display("FAIL delay_wait_status got busy=%b level=%0d want 1/0", oBusy, oLevel); end
        waitObs(1, 200);
        repeat (30) tick();
        // Same delay with iHold covering exactly the second qualifying tick
        pushEntry(16'd3, 5'h05, 8'h42, t, ok);
        expQ.push_back('{a: 5'h05, d: 8'h42, c: modelObs(t, -100, 4, 20)});
        e1 = nextCe(t + 1, 20);
        e2 = e1 + 20;
        while (cyc < e2 - 5) tick();
        iHold = 1'b1;
        while (cyc < e2 + 5) tick();
        iHold = 1'b0;
        waitObs(2, 200);
        repeat (30) tick();
        while (expQ.size() > 0 && obsRd < obsA.size()) begin
            e = expQ.pop_front();
            compared++;
            if (obsA[obsRd] !== e.a || obsD[obsRd] !== e.d || obsC[obsRd] != e.c) begin
                mismatched++;
                $display("FAIL delay_write got a=%h d=%h edge=%0d want a=%h d=%h edge=%0d",
                         obsA[obsRd], obsD[obsRd], obsC[obsRd], e.a, e.d, e.c);
            end
            obsRd++;
        end
        compared++;
        if (expQ.size() != 0 || obsRd != obsA.size()) begin
            mismatched++;
            $display("FAIL delay_count got missing=%0d extra=%0d want 0/0", expQ.size(), obsA.size() - obsRd);
            expQ.delete();
            obsRd = obsA.size();
        end
    endtask

    task automatic test_fill();
        int t;
        int prev;
        int maxLevel;
        bit ok;
        exp_t e;
        cePeriod = 4;
        repeat (3) tick();
        prev = -100;
        maxLevel = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            if (oLevel === 4'd8) begin
                compared++;
                if (oReady !== 1'b0) begin mismatched++; $display("FAIL fill_ready_full got %b want 0", oReady); end
            end
            pushEntry(16'd5, 5'(i + 1), 8'(8'h80 + i), t, ok);
            compared++; if (!ok) begin mismatched++; $display("FAIL fill_push_timeout entry=%0d got not-ready want ready", i); end
            if (int'(oLevel) > maxLevel) maxLevel = int'(oLevel);
            prev = modelObs(t, prev, 5, 4);
            expQ.push_back('{a: 5'(i + 1), d: 8'(8'h80 + i), c: prev});
        end
        waitObs(DEPTH + 2, 400);
        repeat (3) tick();
        while (expQ.size() > 0 && obsRd < obsA.size()) begin
            e = expQ.pop_front();
            compared++;
            if (obsA[obsRd] !== e.a || obsD[obsRd] !== e.d || obsC[obsRd] != e.c) begin
                mismatched++;
                $display("FAIL fill_write got a=%h d=%h edge=%0d want a=%h d=%h edge=%0d",
                         obsA[obsRd], obsD[obsRd], obsC[obsRd], e.a, e.d, e.c);
            end
            obsRd++;
        end
        compared++;
        if (expQ.size() != 0 || obsRd != obsA.size()) begin
            mismatched++;
            $display("FAIL fill_count got missing=%0d extra=%0d want 0/0", expQ.size(), obsA.size() - obsRd);
            expQ.delete();
            obsRd = obsA.size();
        end
        compared++; if (maxLevel != DEPTH) begin mismatched++; $display("FAIL fill_peak_level got %0d want %0d", maxLevel, DEPTH); end
        compared++; if (oLevel !== 4'd0 || oBusy !== 1'b0) begin mismatched++; $display("FAIL fill_drained got level=%0d busy=%b want 0/0", oLevel, oBusy); end
    endtask

    task automatic test_flush();
        int t;
        bit ok;
        cePeriod = 4;
        repeat (3) tick();
        for (int i = 0; i < 4; i++) pushEntry(16'd5, 5'(i + 8), 8'(8'hC0 + i), t, ok);
        repeat (3) tick();
        iFlush = 1'b1;
        iValid = 1'b1;
        iDelay = 16'd0;
        iAddr  = 5'h1F;
        iData  = 8'hEE;
        #1;
        compared++; if (oReady !== 1'b0) begin mismatched++; $display("FAIL flush_ready got %b want 0", oReady); end
        tick();
        iFlush = 1'b0;
        iValid = 1'b0;
        compared++; if (oLevel !== 4'd0) begin mismatched++; $display("FAIL flush_level got %0d want 0", oLevel); end
        compared++; if (oBusy !== 1'b0) begin mismatched++; $display("FAIL flush_idle got busy=%b want 0", oBusy); end
        repeat (120) tick();
        compared++;
        if (obsA.size() != obsRd) begin
            mismatched++;
            $display("FAIL flush_no_strobe got %0d strobes want 0", obsA.size() - obsRd);
            obsRd = obsA.size();
        end
        compared++; if (oLevel !== 4'd0) begin mismatched++; $display("FAIL flush_level_late got %0d want 0", oLevel); end
    endtask

    task automatic test_rst_issue();
        cePeriod = 0;
        repeat (2) tick();
        iValid = 1'b1;
        iDelay = 16'd0;
        iAddr  = 5'h0A;
        iData  = 8'h55;
        tick();
        iAddr  = 5'h0B;
        iData  = 8'h66;
        tick();
        iValid = 1'b0;
        compared++; if (oSidWE !== 1'b1 || oSidAddr !== 5'h0A) begin mismatched++; $display("FAIL rst_pre_issue got we=%b a=%h want 1/0a", oSidWE, oSidAddr); end
        compared++; if (oLevel !== 4'd1) begin mismatched++; $display("FAIL rst_pre_level got %0d want 1", oLevel); end
        rst = 1'b1;
        #1;
        compared++; if (oSidWE !== 1'b0) begin mismatched++; $display("FAIL rst_async_we got %b want 0", oSidWE); end
        compared++; if (oLevel !== 4'd0 || oReady !== 1'b0 || oBusy !== 1'b0) begin mismatched++; $display("FAIL rst_async_state got level=%0d ready=%b busy=%b want 0/0/0", oLevel, oReady, oBusy); end
        tick();
        tick();
        rst = 1'b0;
        #1;
        compared++; if (oReady !== 1'b1 || oLevel !== 4'd0) begin mismatched++; $display("FAIL rst_release got ready=%b level=%0d want 1/0", oReady, oLevel); end
        repeat (10) tick();
        compared++;
        if (obsA.size() != obsRd) begin
            mismatched++;
            $display("FAIL rst_no_strobe got %0d strobes want 0", obsA.size() - obsRd);
            obsRd = obsA.size();
        end
    endtask

    initial begin
        rst    = 1'b1;
        iValid = 1'b0;
        iDelay = 16'd0;
        iAddr  = 5'd0;
        iData  = 8'd0;
        iFlush = 1'b0;
        iHold  = 1'b0;
        test_reset();
        test_zero_delay();
        test_back_to_back();
        test_delay_hold();
        test_fill();
        test_flush();
        test_rst_issue();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
